// File: rtl/pipe_mem_stage_lsu.sv
// Memory-stage load/store unit: req/gnt/rvalid data port, byte-lane store/load alignment, 4:1 writeback mux.
// Optional define LSU_MISALIGN_TRAP_EN: misaligned accesses skip memory and complete with o_misalign set.
module pipe_mem_stage_lsu #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned DMEM_AW = 12
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    output logic                o_stall,
    input  logic                i_mem_rd,
    input  logic                i_mem_wr,
    input  logic [2:0]          i_funct3,
    input  logic [XLEN-1:0]     i_addr,
    input  logic [XLEN-1:0]     i_wdata,
    input  logic [XLEN-1:0]     i_ext_imm,
    input  logic [XLEN-1:0]     i_pc_plus_imm,
    input  logic [XLEN-1:0]     i_pc_plus4,
    input  logic [1:0]          i_wb_sel,
    output logic                o_valid,
    input  logic                i_wb_ready,
    output logic [XLEN-1:0]     o_wb_data,
    output logic                o_misalign,
    output logic                o_dmem_req,
    input  logic                i_dmem_gnt,
    output logic                o_dmem_we,
    output logic [DMEM_AW-1:0]  o_dmem_addr,
    output logic [XLEN/8-1:0]   o_dmem_be,
    output logic [XLEN-1:0]     o_dmem_wdata,
    input  logic                i_dmem_rvalid,
    input  logic [XLEN-1:0]     i_dmem_rdata
);

    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned LB = $clog2(NB);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [XLEN-1:0]    wb_data_q, wb_data_d;
    logic               misalign_q, misalign_d;
    logic               we_q, we_d;
    logic [DMEM_AW-1:0] addr_q, addr_d;
    logic [NB-1:0]      be_q, be_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;
    logic [LB-1:0]      lane_q, lane_d;
    logic [2:0]         funct3_q, funct3_d;

    logic               accept;
    logic               is_mem;
    logic               trap;
    logic [LB-1:0]      lane_in;
    logic [NB-1:0]      be_in;
    logic [XLEN-1:0]    wdata_in;
    logic [XLEN-1:0]    mux_in;
    logic [XLEN-1:0]    shifted;
    logic [XLEN-1:0]    load_ext;

    // Access-size decode; half and full-width accesses drop the low address bits they cannot use.
    always_comb begin : size_decode
        lane_in  = i_addr[LB-1:0];
        be_in    = '0;
        wdata_in = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                be_in    = NB'(1) << lane_in;
                wdata_in = {NB{i_wdata[7:0]}};
            end
            2'b01: begin
                lane_in[0] = 1'b0;
                be_in      = NB'(2'b11) << lane_in;
                wdata_in   = {(NB/2){i_wdata[15:0]}};
            end
            default: begin
                lane_in  = '0;
                be_in    = '1;
                wdata_in = i_wdata;
            end
        endcase
    end

    always_comb begin : wb_mux
        mux_in = i_addr;
        case (i_wb_sel)
            2'd0:    mux_in = i_addr;
            2'd1:    mux_in = i_ext_imm;
            2'd2:    mux_in = i_pc_plus_imm;
            default: mux_in = i_pc_plus4;
        endcase
    end

    always_comb begin : misalign_detect
        is_mem = i_mem_rd | i_mem_wr;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = is_mem & (((i_funct3[1:0] == 2'b01) & i_addr[0]) |
                         (i_funct3[1] & (|i_addr[LB-1:0])));
`else
        trap = 1'b0;
`endif
    end

    always_comb begin : load_align
        shifted  = i_dmem_rdata >> {lane_q, 3'b000};
        load_ext = shifted;
        case (funct3_q)
            3'b000:  load_ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge i_clk) begin : state_reg
        if (i_rst) begin
            state_q    <= S_IDLE;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            lane_q     <= '0;
            funct3_q   <= '0;
        end else begin
            state_q    <= state_d;
            wb_data_q  <= wb_data_d;
            misalign_q <= misalign_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            lane_q     <= lane_d;
            funct3_q   <= funct3_d;
        end
    end

    always_comb begin : next_state
        accept     = i_valid & o_ready;
        state_d    = state_q;
        wb_data_d  = wb_data_q;
        misalign_d = misalign_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        lane_d     = lane_q;
        funct3_d   = funct3_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    misalign_d = trap;
                    wb_data_d  = trap ? i_addr : mux_in;
                    if (is_mem & ~trap) begin
                        // Store wins when both rd and wr are set.
                        we_d     = i_mem_wr;
                        addr_d   = i_addr[DMEM_AW+LB-1:LB];
                        be_d     = be_in;
                        wdata_d  = wdata_in;
                        lane_d   = lane_in;
                        funct3_d = i_funct3;
                        state_d  = S_REQ;
                    end else begin
                        state_d  = S_DONE;
                    end
                end else if ((state_q == S_DONE) && i_wb_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (i_dmem_gnt) begin
                    state_d = we_q ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_dmem_rvalid) begin
                    wb_data_d = load_ext;
                    state_d   = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin : outputs
        logic ready;
        ready        = (state_q == S_IDLE) | ((state_q == S_DONE) & i_wb_ready);
        o_ready      = ready;
        o_stall      = i_valid & ~ready;
        o_valid      = (state_q == S_DONE);
        o_dmem_req   = (state_q == S_REQ);
        o_dmem_we    = we_q & (state_q == S_REQ);
        o_dmem_addr  = addr_q;
        o_dmem_be    = be_q;
        o_dmem_wdata = wdata_q;
        o_wb_data    = wb_data_q;
        o_misalign   = misalign_q;
    end

endmodule

// File: tb/tb_pipe_mem_stage_lsu.sv
// Randomized scoreboard bench for pipe_mem_stage_lsu with a byte-level reference memory model.
// Follows LSU_MISALIGN_TRAP_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_pipe_mem_stage_lsu;

    localparam int N_RAND = 400;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready, o_stall;
    logic        i_mem_rd = 1'b0, i_mem_wr = 1'b0;
    logic [2:0]  i_funct3 = '0;
    logic [31:0] i_addr = '0, i_wdata = '0, i_ext_imm = '0, i_pc_plus_imm = '0, i_pc_plus4 = '0;
    logic [1:0]  i_wb_sel = '0;
    logic        o_valid;
    logic        i_wb_ready = 1'b0;
    logic [31:0] o_wb_data;
    logic        o_misalign;
    logic        o_dmem_req;
    logic        i_dmem_gnt = 1'b0;
    logic        o_dmem_we;
    logic [11:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_rvalid = 1'b0;
    logic [31:0] i_dmem_rdata = '0;

    always #5 i_clk = ~i_clk;

    pipe_mem_stage_lsu #(.XLEN(32), .DMEM_AW(12)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready), .o_stall(o_stall),
        .i_mem_rd(i_mem_rd), .i_mem_wr(i_mem_wr), .i_funct3(i_funct3), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_ext_imm(i_ext_imm), .i_pc_plus_imm(i_pc_plus_imm),
        .i_pc_plus4(i_pc_plus4), .i_wb_sel(i_wb_sel), .o_valid(o_valid), .i_wb_ready(i_wb_ready),
        .o_wb_data(o_wb_data), .o_misalign(o_misalign), .o_dmem_req(o_dmem_req),
        .i_dmem_gnt(i_dmem_gnt), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata), .i_dmem_rvalid(i_dmem_rvalid),
        .i_dmem_rdata(i_dmem_rdata)
    );

    typedef struct packed { logic [31:0] data; logic mis; } wb_exp_t;
    typedef struct packed { logic we; logic [11:0] addr; logic [3:0] be; logic [31:0] wdata; } req_exp_t;

    wb_exp_t     wb_q[$];
    req_exp_t    req_q[$];
    logic [31:0] dmem [0:63];      // memory behind the DUT's port, written by its grants
    logic [7:0]  ref_mem [0:255];  // reference byte image updated at acceptance

    int n_checks = 0;
    int n_pass   = 0;
    bit auto_resp = 1'b1;
    logic man_gnt = 1'b0, man_rvalid = 1'b0;
    logic [31:0] man_rdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name, input string why);
        n_checks++;
        $display("FAIL %s: %s at %0t", name, why, $time);
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Reference behaviour at acceptance: expected writeback, expected request, memory effect.
    task automatic model_accept(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] muxv);
        int sz;
        int base;
        wb_exp_t  e;
        req_exp_t r;
        logic [31:0] v;
        sz   = acc_size(f3);
        base = int'(a[7:0]) / sz * sz;
        e.mis = 1'b0;
        if (!(rd || wr)) begin
            e.data = muxv;
            wb_q.push_back(e);
        end else if (TRAP && ((sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00))) begin
            e.data = a;
            e.mis  = 1'b1;
            wb_q.push_back(e);
        end else begin
            r.we    = wr;
            r.addr  = a[13:2];
            r.be    = '0;
            r.wdata = '0;
            for (int i = 0; i < sz; i++) r.be[(base % 4) + i] = 1'b1;
            for (int l = 0; l < 4; l++) r.wdata[8*l +: 8] = wd[8*(l % sz) +: 8];
            req_q.push_back(r);
            if (wr) begin
                for (int i = 0; i < sz; i++) ref_mem[base + i] = wd[8*i +: 8];
                e.data = muxv;
            end else begin
                v = '0;
                for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[base + i];
                if (!f3[2] && sz == 1 && v[7])  v = v | 32'hFFFF_FF00;
                if (!f3[2] && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
                e.data = v;
            end
            wb_q.push_back(e);
        end
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] eimm, input logic [31:0] ppi,
                         input logic [31:0] pp4, input logic [1:0] sel, input bit track);
        bit done;
        logic [31:0] muxv;
        done = 1'b0;
        muxv = (sel == 2'd0) ? a : (sel == 2'd1) ? eimm : (sel == 2'd2) ? ppi : pp4;
        i_valid = 1'b1; i_mem_rd = rd; i_mem_wr = wr; i_funct3 = f3; i_addr = a; i_wdata = wd;
        i_ext_imm = eimm; i_pc_plus_imm = ppi; i_pc_plus4 = pp4; i_wb_sel = sel;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge i_clk);
            if (o_ready) begin
                done = 1'b1;
                if (track) model_accept(rd, wr, f3, a, wd, muxv);
            end
            @(posedge i_clk); #1;
        end
        if (!done) fail_now("accept_timeout", "o_ready never seen within 200 cycles, required acceptance");
        i_valid = 1'b0;
    endtask

    initial begin : wb_ready_gen
        forever begin
            @(posedge i_clk); #1;
            i_wb_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : responder
        bit gnt_armed = 1'b0;
        int gnt_wait  = 0;
        bit rd_pending = 1'b0;
        int rd_wait   = 0;
        int rd_word   = 0;
        req_exp_t got;
        forever begin
            @(posedge i_clk); #1;
            if (!auto_resp) begin
                i_dmem_gnt    = man_gnt;
                i_dmem_rvalid = man_rvalid;
                i_dmem_rdata  = man_rdata;
                gnt_armed  = 1'b0;
                rd_pending = 1'b0;
            end else begin
                i_dmem_gnt    = 1'b0;
                i_dmem_rvalid = 1'b0;
                if (rd_pending) begin
                    if (rd_wait == 0) begin
                        i_dmem_rvalid = 1'b1;
                        i_dmem_rdata  = dmem[rd_word];
                        rd_pending    = 1'b0;
                    end else rd_wait--;
                end else if ($urandom_range(0, 7) == 0) begin
                    i_dmem_rvalid = 1'b1;   // stray response, must be ignored
                    i_dmem_rdata  = $urandom;
                end
                if (o_dmem_req) begin
                    got = {o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata};
                    if (req_q.size() == 0) fail_now("unexpected_req", "o_dmem_req=1, required no request");
                    else chk("dmem_req_fields", got, req_q[0]);
                    if (!gnt_armed) begin
                        gnt_armed = 1'b1;
                        gnt_wait  = $urandom_range(0, 3);
                    end
                    if (gnt_wait == 0) begin
                        i_dmem_gnt = 1'b1;
                        gnt_armed  = 1'b0;
                        if (req_q.size() != 0) void'(req_q.pop_front());
                        if (o_dmem_we) begin
                            for (int l = 0; l < 4; l++)
                                if (o_dmem_be[l]) dmem[int'(o_dmem_addr[5:0])][8*l +: 8] = o_dmem_wdata[8*l +: 8];
                        end else begin
                            rd_pending = 1'b1;
                            rd_wait    = $urandom_range(0, 3);
                            rd_word    = int'(o_dmem_addr[5:0]);
                        end
                    end else gnt_wait--;
                end else if ($urandom_range(0, 7) == 0) begin
                    i_dmem_gnt = 1'b1;      // stray grant, must be ignored
                end
            end
        end
    end

    initial begin : monitor
        wb_exp_t e;
        forever begin
            @(negedge i_clk);
            if (!i_rst) begin
                chk("o_stall", o_stall, i_valid & ~o_ready);
                if (o_valid) begin
                    chk("ready_in_done", o_ready, i_wb_ready);
                    if (i_wb_ready) begin
                        if (wb_q.size() == 0) begin
                            fail_now("unexpected_o_valid", $sformatf("o_wb_data=0x%0h, required no output", o_wb_data));
                        end else begin
                            e = wb_q.pop_front();
                            chk("wb_data", o_wb_data, e.data);
                            chk("misalign", o_misalign, e.mis);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        n_checks++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_valid"},    o_valid, 1'b0);
        chk({tag, "_req"},      o_dmem_req, 1'b0);
        chk({tag, "_we"},       o_dmem_we, 1'b0);
        chk({tag, "_misalign"}, o_misalign, 1'b0);
        chk({tag, "_addr"},     o_dmem_addr, 12'h0);
        chk({tag, "_be"},       o_dmem_be, 4'h0);
        chk({tag, "_wdata"},    o_dmem_wdata, 32'h0);
        chk({tag, "_wb_data"},  o_wb_data, 32'h0);
        chk({tag, "_ready"},    o_ready, 1'b1);
    endtask

    initial begin : main
        bit k_rd, k_wr, seen;
        int k, gap;
        logic [31:0] a;
        for (int w = 0; w < 64; w++) begin
            dmem[w] = (w == 0) ? 32'h0080_0000 : $urandom;
            for (int i = 0; i < 4; i++) ref_mem[4*w + i] = dmem[w][8*i +: 8];
        end
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_idle_outputs("reset");
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        issue(0, 0, 3'b000, 32'h0000_0050, 0, 32'h11, 32'h22, 32'h104, 2'd3, 1);   // ALU, pc+4
        issue(0, 1, 3'b000, 32'h0000_0013, 32'hAB, 0, 0, 0, 2'd0, 1);              // SB
        issue(1, 0, 3'b000, 32'h0000_0002, 0, 0, 0, 0, 2'd0, 1);                   // LB
        issue(1, 0, 3'b100, 32'h0000_0002, 0, 0, 0, 0, 2'd0, 1);                   // LBU
        issue(1, 0, 3'b001, 32'h0000_0001, 0, 0, 0, 0, 2'd0, 1);                   // LH misaligned
        issue(1, 0, 3'b010, 32'h0000_0010, 0, 0, 0, 0, 2'd0, 1);                   // LW
        issue(1, 0, 3'b010, 32'h0000_0014, 0, 0, 0, 0, 2'd0, 1);                   // LW back-to-back

        for (int n = 0; n < N_RAND; n++) begin
            k    = $urandom_range(0, 9);
            k_rd = (k >= 3 && k <= 6) || (k == 9);
            k_wr = (k >= 7);
            a    = (k_rd || k_wr) ? 32'($urandom_range(0, 255)) : $urandom;
            issue(k_rd, k_wr, 3'($urandom_range(0, 7)), a, $urandom, $urandom, $urandom, $urandom,
                  2'($urandom_range(0, 3)), 1);
            gap = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            repeat (gap) begin @(posedge i_clk); #1; end
        end

        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge i_clk);
            if (wb_q.size() == 0 && req_q.size() == 0 && o_ready && !o_valid) seen = 1'b1;
        end
        if (!seen) fail_now("drain_timeout", $sformatf("%0d results outstanding, required 0", wb_q.size()));
        @(posedge i_clk); #1;

        // Reset while a load waits for its response; the late response must vanish.
        auto_resp = 1'b0;
        @(posedge i_clk); #1;
        issue(1, 0, 3'b010, 32'h0000_0008, 0, 0, 0, 0, 2'd0, 0);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge i_clk);
            if (o_dmem_req) seen = 1'b1;
        end
        if (!seen) fail_now("reset_test_req", "o_dmem_req stayed 0, required 1");
        man_gnt = 1'b1;
        @(posedge i_clk); #2;
        man_gnt = 1'b0;
        @(posedge i_clk); #2;
        i_rst = 1'b1;
        @(posedge i_clk); #2;
        i_rst = 1'b0;
        man_rvalid = 1'b1;
        man_rdata  = 32'h1234_5678;
        @(posedge i_clk); #2;
        man_rvalid = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            check_idle_outputs("post_reset");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
